// File: rtl/lcd_rgb_rx_if.sv
// LCD parallel-RGB receive bundle: raw sync/DE/pixel lines in, recovered pixels and frame status out.
// No latency of its own; no backpressure: the LCD source streams continuously.
// The slave side is the receiver, the master side is the source/consumer.
interface lcd_rgb_rx_if;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [15:0] lcd_rgb;
    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic [9:0]  pixel_xpos;
    logic [9:0]  pixel_ypos;
    logic        frame_start;
    logic        line_end;
    logic [10:0] meas_width;
    logic [10:0] meas_height;
    logic        meas_valid;
    logic        frame_err;
    logic        locked;

    modport master (
        output lcd_hs, lcd_vs, lcd_de, lcd_rgb,
        input  pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end,
        input  meas_width, meas_height, meas_valid, frame_err, locked
    );

    modport slave (
        input  lcd_hs, lcd_vs, lcd_de, lcd_rgb,
        output pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start, line_end,
        output meas_width, meas_height, meas_valid, frame_err, locked
    );
endinterface

// File: rtl/lcd_rgb_rx.sv
// RGB LCD receiver: recovers pixel x/y/data, measures frame geometry, flags timing errors, reports lock.
// Latency: fixed 2 cycles from input pins to every output (input sample stage + output register).
// No backpressure: pixels are emitted as they arrive; the consumer must keep up with lcd_clk.
module lcd_rgb_rx #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter int VS_POL      = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic         lcd_clk,
    input  logic         sys_rst,
    lcd_rgb_rx_if.slave  bus
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    state_t      state;
    logic        s1_vs, s2_vs, s1_de, s2_de;
    logic [15:0] s1_rgb;
    logic [9:0]  x_cnt, y_cnt;
    logic [10:0] line_cnt, ref_width;
    logic        err_flag;
    logic [GW-1:0] good_cnt, good_next;
    logic        vs_rise, de_fall, bad_close;

    // s1_vs/s2_vs hold "vsync active" independent of polarity
    assign vs_rise   = s1_vs & ~s2_vs;
    assign de_fall   = s2_de & ~s1_de;
    assign good_next = (good_cnt == GW'(LOCK_FRAMES)) ? good_cnt : good_cnt + 1'b1;
    // A line still open at the boundary (x_cnt != 0 or DE high) makes the frame truncated
    assign bad_close = err_flag || (x_cnt != 10'd0) || s1_de
                    || (ref_width != 11'(H_ACTIVE)) || (line_cnt != 11'(V_ACTIVE));

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= WAIT_VS;
            s1_vs           <= 1'b0;
            s2_vs           <= 1'b0;
            s1_de           <= 1'b0;
            s2_de           <= 1'b0;
            s1_rgb          <= '0;
            x_cnt           <= '0;
            y_cnt           <= '0;
            line_cnt        <= '0;
            ref_width       <= '0;
            err_flag        <= 1'b0;
            good_cnt        <= '0;
            bus.pixel_valid <= 1'b0;
            bus.pixel_data  <= '0;
            bus.pixel_xpos  <= '0;
            bus.pixel_ypos  <= '0;
            bus.frame_start <= 1'b0;
            bus.line_end    <= 1'b0;
            bus.meas_width  <= '0;
            bus.meas_height <= '0;
            bus.meas_valid  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.locked      <= 1'b0;
        end else begin
            s1_vs           <= (bus.lcd_vs == 1'(VS_POL));
            s2_vs           <= s1_vs;
            s1_de           <= bus.lcd_de;
            s2_de           <= s1_de;
            s1_rgb          <= bus.lcd_rgb;
            bus.pixel_valid <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.line_end    <= 1'b0;

            case (state)
                WAIT_VS: begin
                    if (vs_rise) begin
                        bus.frame_start <= 1'b1;
                        x_cnt           <= '0;
                        y_cnt           <= '0;
                        line_cnt        <= '0;
                        ref_width       <= '0;
                        err_flag        <= 1'b0;
                        state           <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        bus.meas_width  <= ref_width;
                        bus.meas_height <= line_cnt;
                        bus.meas_valid  <= 1'b1;
                        bus.frame_err   <= bad_close;
                        good_cnt        <= bad_close ? '0 : good_next;
                        bus.locked      <= !bad_close && (good_next == GW'(LOCK_FRAMES));
                        bus.frame_start <= 1'b1;
                        y_cnt           <= '0;
                        line_cnt        <= '0;
                        ref_width       <= '0;
                        // A pixel on the boundary cycle belongs to the new frame at (0,0)
                        if (s1_de) begin
                            bus.pixel_valid <= 1'b1;
                            bus.pixel_data  <= s1_rgb;
                            bus.pixel_xpos  <= '0;
                            bus.pixel_ypos  <= '0;
                            x_cnt           <= 10'd1;
                            err_flag        <= 1'b1;
                        end else begin
                            x_cnt           <= '0;
                            err_flag        <= 1'b0;
                        end
                    end else if (s1_de) begin
                        bus.pixel_valid <= 1'b1;
                        bus.pixel_data  <= s1_rgb;
                        bus.pixel_xpos  <= x_cnt;
                        bus.pixel_ypos  <= y_cnt;
                        if (x_cnt != '1)
                            x_cnt <= x_cnt + 10'd1;
                        if ((x_cnt == '1) || s1_vs)
                            err_flag <= 1'b1;
                    end else if (de_fall) begin
                        bus.line_end <= 1'b1;
                        x_cnt        <= '0;
                        if (line_cnt == 11'd0)
                            ref_width <= {1'b0, x_cnt};
                        else if ({1'b0, x_cnt} != ref_width)
                            err_flag <= 1'b1;
                        if (y_cnt == '1)
                            err_flag <= 1'b1;
                        else
                            y_cnt <= y_cnt + 10'd1;
                        if (line_cnt != '1)
                            line_cnt <= line_cnt + 11'd1;
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx on a 4x3 geometry with two-frame lock.
// Inputs change 1 ns after each rising edge; a negedge monitor tallies output pulses.
module tb_lcd_rgb_rx;
    logic lcd_clk = 1'b0;
    logic sys_rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    int pv_cnt = 0, le_cnt = 0, fs_cnt = 0, data_bad = 0;
    int last_x = -1, last_y = -1;

    lcd_rgb_rx_if bus ();

    lcd_rgb_rx #(.H_ACTIVE(4), .V_ACTIVE(3), .VS_POL(0), .LOCK_FRAMES(2)) dut (
        .lcd_clk (lcd_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 lcd_clk = ~lcd_clk;

    // Source pixels carry their own coordinates so the monitor can cross-check data
    function automatic logic [15:0] pat(input int x, input int y);
        logic [9:0] xv;
        logic [5:0] yv;
        xv = x[9:0];
        yv = y[5:0];
        return {yv, xv};
    endfunction

    always @(negedge lcd_clk) begin
        if (!sys_rst) begin
            if (bus.pixel_valid) begin
                pv_cnt++;
                last_x = int'(bus.pixel_xpos);
                last_y = int'(bus.pixel_ypos);
                if (bus.pixel_data !== {bus.pixel_ypos[5:0], bus.pixel_xpos})
                    data_bad++;
            end
            if (bus.line_end)    le_cnt++;
            if (bus.frame_start) fs_cnt++;
        end
    end

    task automatic cyc(input logic vs, input logic de, input logic [15:0] rgb);
        @(posedge lcd_clk);
        #1;
        bus.lcd_vs  = vs;
        bus.lcd_de  = de;
        bus.lcd_rgb = rgb;
        bus.lcd_hs  = ~de;
    endtask

    task automatic line(input int y, input int w);
        for (int x = 0; x < w; x++) cyc(1'b1, 1'b1, pat(x, y));
        repeat (3) cyc(1'b1, 1'b0, 16'h0);
    endtask

    task automatic vsync_pulse();
        repeat (2) cyc(1'b0, 1'b0, 16'h0);
        repeat (3) cyc(1'b1, 1'b0, 16'h0);
    endtask

    task automatic test_reset();
        bus.lcd_vs = 1'b1; bus.lcd_de = 1'b0; bus.lcd_rgb = 16'h0; bus.lcd_hs = 1'b1;
        #1 sys_rst = 1'b1;
        repeat (2) @(negedge lcd_clk);
        n_chk++; if (bus.pixel_valid !== 1'b0) $display("FAIL rst_pv: got %b want 0", bus.pixel_valid); else n_pass++;
        n_chk++; if (bus.frame_start !== 1'b0) $display("FAIL rst_fs: got %b want 0", bus.frame_start); else n_pass++;
        n_chk++; if (bus.meas_valid !== 1'b0) $display("FAIL rst_mv: got %b want 0", bus.meas_valid); else n_pass++;
        n_chk++; if (bus.locked !== 1'b0) $display("FAIL rst_lock: got %b want 0", bus.locked); else n_pass++;
        n_chk++; if (bus.meas_width !== 11'd0) $display("FAIL rst_mw: got %0d want 0", bus.meas_width); else n_pass++;
        sys_rst = 1'b0;
    endtask

    task automatic test_pre_vsync();
        int pv0, le0;
        pv0 = pv_cnt; le0 = le_cnt;
        for (int y = 0; y < 5; y++) line(y, 4);
        n_chk++; if (pv_cnt - pv0 !== 0) $display("FAIL pre_pv: got %0d want 0", pv_cnt - pv0); else n_pass++;
        n_chk++; if (le_cnt - le0 !== 0) $display("FAIL pre_le: got %0d want 0", le_cnt - le0); else n_pass++;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        n_chk++; if (bus.frame_start !== 1'b0) $display("FAIL fs_early: got %b want 0", bus.frame_start); else n_pass++;
        cyc(1'b1, 1'b0, 16'h0);
        n_chk++; if (bus.frame_start !== 1'b1) $display("FAIL fs_lat2: got %b want 1", bus.frame_start); else n_pass++;
        cyc(1'b1, 1'b0, 16'h0);
        n_chk++; if (bus.frame_start !== 1'b0) $display("FAIL fs_pulse: got %b want 0", bus.frame_start); else n_pass++;
        cyc(1'b1, 1'b0, 16'h0);
    endtask

    task automatic test_nominal();
        int pv0, le0, fs0;
        pv0 = pv_cnt; le0 = le_cnt; fs0 = fs_cnt;
        for (int y = 0; y < 3; y++) line(y, 4);
        vsync_pulse();
        n_chk++; if (pv_cnt - pv0 !== 12) $display("FAIL nom_pv: got %0d want 12", pv_cnt - pv0); else n_pass++;
        n_chk++; if (le_cnt - le0 !== 3) $display("FAIL nom_le: got %0d want 3", le_cnt - le0); else n_pass++;
        n_chk++; if (fs_cnt - fs0 !== 1) $display("FAIL nom_fs: got %0d want 1", fs_cnt - fs0); else n_pass++;
        n_chk++; if (last_x !== 3 || last_y !== 2) $display("FAIL nom_last: got x=%0d y=%0d want x=3 y=2", last_x, last_y); else n_pass++;
        n_chk++; if (bus.meas_width !== 11'd4) $display("FAIL nom_mw: got %0d want 4", bus.meas_width); else n_pass++;
        n_chk++; if (bus.meas_height !== 11'd3) $display("FAIL nom_mh: got %0d want 3", bus.meas_height); else n_pass++;
        n_chk++; if (bus.meas_valid !== 1'b1) $display("FAIL nom_mv: got %b want 1", bus.meas_valid); else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL nom_err1: got %b want 0", bus.frame_err); else n_pass++;
        n_chk++; if (bus.locked !== 1'b0) $display("FAIL nom_lock1: got %b want 0", bus.locked); else n_pass++;
        for (int y = 0; y < 3; y++) line(y, 4);
        vsync_pulse();
        n_chk++; if (bus.frame_err !== 1'b0) $display("FAIL nom_err2: got %b want 0", bus.frame_err); else n_pass++;
        n_chk++; if (bus.locked !== 1'b1) $display("FAIL nom_lock2: got %b want 1", bus.locked); else n_pass++;
    endtask

    task automatic test_latency();
        cyc(1'b1, 1'b1, pat(0, 0));
        n_chk++; if (bus.pixel_valid !== 1'b0) $display("FAIL lat_pv0: got %b want 0", bus.pixel_valid); else n_pass++;
        cyc(1'b1, 1'b1, pat(1, 0));
        n_chk++; if (bus.pixel_valid !== 1'b0) $display("FAIL lat_pv1: got %b want 0", bus.pixel_valid); else n_pass++;
        cyc(1'b1, 1'b1, pat(2, 0));
        n_chk++; if (bus.pixel_valid !== 1'b1) $display("FAIL lat_pv2: got %b want 1", bus.pixel_valid); else n_pass++;
        n_chk++; if (bus.pixel_data !== 16'h0000 || bus.pixel_xpos !== 10'd0 || bus.pixel_ypos !== 10'd0)
            $display("FAIL lat_pix: got d=%h x=%0d y=%0d want d=0000 x=0 y=0", bus.pixel_data, bus.pixel_xpos, bus.pixel_ypos);
        else n_pass++;
        cyc(1'b1, 1'b1, pat(3, 0));
        n_chk++; if (bus.pixel_data !== 16'h0001 || bus.pixel_xpos !== 10'd1) $display("FAIL lat_pix1: got d=%h x=%0d want d=0001 x=1", bus.pixel_data, bus.pixel_xpos); else n_pass++;
        repeat (3) cyc(1'b1, 1'b0, 16'h0);
        line(1, 4);
        line(2, 4);
        vsync_pulse();
        n_chk++; if (bus.locked !== 1'b1) $display("FAIL lat_lock: got %b want 1", bus.locked); else n_pass++;
    endtask

    task automatic test_width_glitch();
        line(0, 4); line(1, 3); line(2, 4);
        vsync_pulse();
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL wg_err: got %b want 1", bus.frame_err); else n_pass++;
        n_chk++; if (bus.locked !== 1'b0) $display("FAIL wg_lock: got %b want 0", bus.locked); else n_pass++;
        n_chk++; if (bus.meas_width !== 11'd4) $display("FAIL wg_mw: got %0d want 4", bus.meas_width); else n_pass++;
        for (int y = 0; y < 3; y++) line(y, 4);
        vsync_pulse();
        n_chk++; if (bus.locked !== 1'b0 || bus.frame_err !== 1'b0) $display("FAIL wg_relock1: got lock=%b err=%b want lock=0 err=0", bus.locked, bus.frame_err); else n_pass++;
        for (int y = 0; y < 3; y++) line(y, 4);
        vsync_pulse();
        n_chk++; if (bus.locked !== 1'b1) $display("FAIL wg_relock2: got %b want 1", bus.locked); else n_pass++;
    endtask

    task automatic test_truncated();
        int le0;
        le0 = le_cnt;
        line(0, 4); line(1, 4);
        cyc(1'b1, 1'b1, pat(0, 2));
        cyc(1'b1, 1'b1, pat(1, 2));
        cyc(1'b0, 1'b1, pat(0, 0));
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0);
        n_chk++; if (bus.frame_start !== 1'b1) $display("FAIL tr_fs: got %b want 1", bus.frame_start); else n_pass++;
        n_chk++; if (bus.pixel_valid !== 1'b1 || bus.pixel_xpos !== 10'd0 || bus.pixel_ypos !== 10'd0)
            $display("FAIL tr_pix: got v=%b x=%0d y=%0d want v=1 x=0 y=0", bus.pixel_valid, bus.pixel_xpos, bus.pixel_ypos);
        else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL tr_err: got %b want 1", bus.frame_err); else n_pass++;
        n_chk++; if (bus.meas_height !== 11'd2) $display("FAIL tr_mh: got %0d want 2", bus.meas_height); else n_pass++;
        n_chk++; if (le_cnt - le0 !== 2) $display("FAIL tr_le: got %0d want 2", le_cnt - le0); else n_pass++;
        n_chk++; if (bus.locked !== 1'b0) $display("FAIL tr_lock: got %b want 0", bus.locked); else n_pass++;
        repeat (2) cyc(1'b1, 1'b0, 16'h0);
    endtask

    task automatic test_zero_frame();
        vsync_pulse();
        vsync_pulse();
        n_chk++; if (bus.meas_height !== 11'd0 || bus.meas_width !== 11'd0)
            $display("FAIL zero_meas: got w=%0d h=%0d want w=0 h=0", bus.meas_width, bus.meas_height);
        else n_pass++;
        n_chk++; if (bus.frame_err !== 1'b1) $display("FAIL zero_err: got %b want 1", bus.frame_err); else n_pass++;
    endtask

    task automatic test_small_geom();
        for (int f = 0; f < 3; f++) begin
            line(0, 4); line(1, 4);
            vsync_pulse();
            n_chk++; if (bus.meas_height !== 11'd2 || bus.frame_err !== 1'b1 || bus.locked !== 1'b0)
                $display("FAIL sg_4x2_f%0d: got h=%0d err=%b lock=%b want h=2 err=1 lock=0", f, bus.meas_height, bus.frame_err, bus.locked);
            else n_pass++;
        end
        for (int y = 0; y < 3; y++) line(y, 4);
        vsync_pulse();
        n_chk++; if (bus.meas_height !== 11'd3 || bus.frame_err !== 1'b0)
            $display("FAIL sg_4x3: got h=%0d err=%b want h=3 err=0", bus.meas_height, bus.frame_err);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        int pv0;
        cyc(1'b1, 1'b1, pat(0, 0));
        cyc(1'b1, 1'b1, pat(1, 0));
        cyc(1'b1, 1'b1, pat(2, 0));
        n_chk++; if (bus.pixel_valid !== 1'b1) $display("FAIL rm_pre: got %b want 1", bus.pixel_valid); else n_pass++;
        #2 sys_rst = 1'b1;
        #1;
        n_chk++; if (bus.pixel_valid !== 1'b0) $display("FAIL rm_pv: got %b want 0", bus.pixel_valid); else n_pass++;
        n_chk++; if (bus.meas_valid !== 1'b0 || bus.meas_height !== 11'd0 || bus.meas_width !== 11'd0)
            $display("FAIL rm_meas: got v=%b w=%0d h=%0d want 0 0 0", bus.meas_valid, bus.meas_width, bus.meas_height);
        else n_pass++;
        bus.lcd_de = 1'b0;
        #3 sys_rst = 1'b0;
        pv0 = pv_cnt;
        line(0, 4); line(1, 4);
        n_chk++; if (pv_cnt - pv0 !== 0) $display("FAIL rm_nopix: got %0d want 0", pv_cnt - pv0); else n_pass++;
        vsync_pulse();
        n_chk++; if (bus.meas_valid !== 1'b0) $display("FAIL rm_mv0: got %b want 0", bus.meas_valid); else n_pass++;
        for (int y = 0; y < 3; y++) line(y, 4);
        vsync_pulse();
        n_chk++; if (bus.meas_valid !== 1'b1 || bus.frame_err !== 1'b0 || bus.meas_height !== 11'd3)
            $display("FAIL rm_frame: got v=%b err=%b h=%0d want v=1 err=0 h=3", bus.meas_valid, bus.frame_err, bus.meas_height);
        else n_pass++;
        n_chk++; if (bus.locked !== 1'b0) $display("FAIL rm_lock: got %b want 0", bus.locked); else n_pass++;
    endtask

    task automatic test_data();
        n_chk++; if (data_bad !== 0) $display("FAIL data_match: got %0d bad pixels want 0", data_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pre_vsync();
        test_nominal();
        test_latency();
        test_width_glitch();
        test_truncated();
        test_zero_frame();
        test_small_geom();
        test_reset_midline();
        test_data();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
